cpu_control_fsm: RTL and testbench
==================================

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 Parameter RESET_PC, default 8'h00, value loaded into pc on reset.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum FETCH wait cycles with mem_ready low; 0 disables timeout.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 instr  input  8  fetched instruction; [7:4] opcode, [3:0] operand.
REQ-006 mem_ready  input  1  memory has instr valid this cycle.
REQ-007 zero_flag  input  1  accumulator-is-zero status from datapath.
REQ-008 pc  output  8  program counter / fetch address.
REQ-009 mem_req  output  1  fetch request to instruction memory.
REQ-010 ir_load  output  1  one-cycle strobe: instr captured.
REQ-011 alu_op  output  3  ALU function select, valid while acc_load high.
REQ-012 alu_src_imm  output  1  1 = ALU B operand is the 4-bit operand zero-extended.
REQ-013 acc_load  output  1  one-cycle strobe: accumulator register loads ALU result.
REQ-014 halted  output  1  high in HALT state.
REQ-015 fault  output  1  high in FAULT state.

Function
REQ-016 States SHALL be FETCH, DECODE, EXECUTE, HALT, FAULT.
REQ-017 FETCH: mem_req=1; when mem_ready=1, ir_load=1 that cycle, instr latched into internal IR, pc increments (8'hFF wraps to 8'h00), next state DECODE.
REQ-018 FETCH with mem_ready=0: stay in FETCH, wait counter increments; entering FETCH clears the counter.
REQ-019 When MEM_TIMEOUT>0 and wait counter reaches MEM_TIMEOUT with mem_ready still 0, next state SHALL be FAULT.
REQ-020 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI, 7 JMP, 8 JZ, F HLT; 9-E SHALL decode as NOP.
REQ-021 DECODE (one cycle): ALU ops and LDI -> EXECUTE; NOP -> FETCH; HLT -> HALT.
REQ-022 JMP in DECODE: pc <= {pc[7:4], operand}, -> FETCH.
REQ-023 JZ in DECODE: zero_flag sampled that cycle; if 1, pc <= {pc[7:4], operand}; else pc unchanged; -> FETCH.
REQ-024 EXECUTE (one cycle): acc_load=1, alu_op per opcode (ADD 0, SUB 1, AND 2, OR 3, XOR 4, PASS_B 5 for LDI), alu_src_imm=1, -> FETCH.
REQ-025 mem_req, ir_load, acc_load SHALL be 0 outside the states named above.
REQ-026 Minimum instruction latency: ALU/LDI 3 cycles, NOP/JMP/JZ 2 cycles, plus memory wait cycles.
REQ-027 HALT and FAULT SHALL be sticky until rst; mem_req=0, pc frozen.
REQ-028 Outputs strobes SHALL be decoded from registered state only (plus mem_ready for ir_load); no other input-to-output paths.

Reset
REQ-029 rst=1 SHALL immediately force state FETCH, pc=RESET_PC, IR=8'h00, wait counter=0.
REQ-030 During reset, mem_req, ir_load, acc_load, halted, fault SHALL be 0 and alu_op=0, alu_src_imm=0.
REQ-031 Reset asserted mid-instruction SHALL abandon it; no acc_load issued for the aborted instruction.
REQ-032 After rst deasserts, first fetch begins on the next rising edge with mem_req=1.

Structure
REQ-033 Shared package cpu_pkg SHALL hold opcode constants, alu_op codes and the state enumeration.
REQ-034 Wait counter SHALL be sub-module mem_wait_timer (clear, enable, limit in; expired out).
REQ-035 Counter width SHALL be sized to hold MEM_TIMEOUT.

Verification
REQ-036 instr=8'h13 (ADD #3), mem_ready=1 constant -> ir_load cycle 0, acc_load cycle 2, alu_op=0, alu_src_imm=1, pc 00->01.
REQ-037 pc=8'h3A, instr=8'h75 (JMP 5) -> pc=8'h35 after DECODE, no acc_load.
REQ-038 instr=8'h89 with zero_flag=0 then 1 -> pc unchanged then pc={pc[7:4],4'h9}.
REQ-039 mem_ready held 0 for 15 cycles, MEM_TIMEOUT=15 -> fault=1, mem_req=0, stays after mem_ready=1.
REQ-040 instr=8'hF0 -> halted=1 after DECODE, pc frozen; rst pulse -> pc=RESET_PC, FETCH.
REQ-041 pc=8'hFF fetch -> pc=8'h00; rst asserted in EXECUTE cycle of ADD -> acc_load stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: states, opcodes, ALU codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_HALT    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_PASS_B = 3'd5;

    // Opcodes that need the EXECUTE cycle to write the accumulator.
    function automatic logic is_exec_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LDI);
    endfunction

    // ALU function select for an accumulator-writing opcode.
    function automatic logic [2:0] alu_code(input logic [3:0] op);
        logic [2:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            OP_XOR:  code = ALU_XOR;
            OP_LDI:  code = ALU_PASS_B;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive fetch wait cycles and flags when the limit is reached.
// Latency: expired is combinational on the current count and enable.
// Backpressure: none; clear has priority over enable, limit of 0 never expires.
module mem_wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);
    import cpu_pkg::*;

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   count_inc;

    // The wait that brings the count up to the limit is the one that expires.
    always_comb begin
        count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
        expired   = enable && (limit != '0) && (count_inc >= {1'b0, limit});
    end

    // Wait counter: cleared outside waiting, advances once per waited cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count_inc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute sequencer for an 8-bit accumulator CPU with fetch timeout.
// Latency: ALU/LDI 3 cycles, NOP/JMP/JZ 2 cycles, plus memory wait cycles.
// Backpressure: FETCH stalls while mem_ready is low; faults after MEM_TIMEOUT waits.
module cpu_control_fsm #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       mem_ready,
    input  logic       zero_flag,
    output logic [7:0] pc,
    output logic       mem_req,
    output logic       ir_load,
    output logic [2:0] alu_op,
    output logic       alu_src_imm,
    output logic       acc_load,
    output logic       halted,
    output logic       fault
);
    import cpu_pkg::*;

    localparam int               CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       run_q;
    logic [3:0] opcode;
    logic       tmr_clear;
    logic       tmr_en;
    logic       tmr_expired;

    assign opcode = ir_q[7:4];
    assign pc     = pc_q;

    mem_wait_timer #(
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .limit   (LIMIT),
        .expired (tmr_expired)
    );

    // State, PC and IR registers; run_q holds off the first fetch until the edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state, next-PC and output decode from registered state (mem_ready only gates ir_load).
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        mem_req     = 1'b0;
        ir_load     = 1'b0;
        acc_load    = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        tmr_clear   = 1'b1;
        tmr_en      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load = 1'b1;
                        ir_d    = instr;
                        pc_d    = pc_q + 8'd1;
                        state_d = ST_DECODE;
                    end else begin
                        tmr_clear = 1'b0;
                        tmr_en    = 1'b1;
                        if (tmr_expired) begin
                            state_d = ST_FAULT;
                        end
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                if (is_exec_op(opcode)) begin
                    state_d = ST_EXECUTE;
                end else if (opcode == OP_JMP) begin
                    pc_d = {pc_q[7:4], ir_q[3:0]};
                end else if (opcode == OP_JZ) begin
                    if (zero_flag) begin
                        pc_d = {pc_q[7:4], ir_q[3:0]};
                    end
                end else if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end
            end
            ST_EXECUTE: begin
                acc_load    = 1'b1;
                alu_op      = alu_code(opcode);
                alu_src_imm = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed instruction stream with an ALU scoreboard.
// Latency: checks ir_load/decode/execute cycle placement per instruction.
// Backpressure: exercises fetch waits, timeout fault, halt and reset aborts.
module tb_cpu_control_fsm;

    localparam logic [7:0] RESET_PC = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instr;
    logic       mem_ready;
    logic       zero_flag;
    logic [7:0] pc;
    logic       mem_req;
    logic       ir_load;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       acc_load;
    logic       halted;
    logic       fault;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] acc_q[$];
    logic [7:0] exp_pc;

    cpu_control_fsm #(
        .RESET_PC    (RESET_PC),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .zero_flag   (zero_flag),
        .pc          (pc),
        .mem_req     (mem_req),
        .ir_load     (ir_load),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .acc_load    (acc_load),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ALU select table for accumulator-writing opcodes.
    function automatic logic [2:0] exp_alu(input logic [3:0] op);
        case (op)
            4'h1:    return 3'd0;
            4'h2:    return 3'd1;
            4'h3:    return 3'd2;
            4'h4:    return 3'd3;
            4'h5:    return 3'd4;
            4'h6:    return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic is_exec(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h6);
    endfunction

    // Scoreboard: every acc_load strobe must match the oldest queued ALU expectation.
    always @(negedge clk) begin
        if (acc_load === 1'b1) begin
            if (acc_q.size() == 0) begin
                chk("acc_unexpected", 32'd1, 32'd0);
            end else begin
                logic [2:0] e;
                e = acc_q.pop_front();
                chk("alu_op", 32'(alu_op), 32'(e));
                chk("alu_src_imm", 32'(alu_src_imm), 32'd1);
            end
        end
    end

    // Pulse reset and return one cycle after release, when the first fetch is live.
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        zero_flag = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'(RESET_PC));
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_acc_load", 32'(acc_load), 32'd0);
        chk("rst_flags", 32'({halted, fault, ir_load}), 32'd0);
        chk("rst_alu", 32'({alu_op, alu_src_imm}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        exp_pc = RESET_PC;
    endtask

    // One instruction: nwait stalled fetch cycles, fetch, decode, optional execute.
    task automatic run_instr(input logic [7:0] i, input logic zf, input int nwait);
        logic [3:0] op;
        op = i[7:4];
        chk("pc_fetch", 32'(pc), 32'(exp_pc));
        for (int k = 0; k < nwait; k++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            chk("wait_req", 32'({mem_req, ir_load, fault}), 32'b100);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        instr = i;
        @(negedge clk);
        chk("ir_load", 32'({mem_req, ir_load}), 32'b11);
        if (is_exec(op)) acc_q.push_back(exp_alu(op));
        @(posedge clk); #1;
        mem_ready = 1'b0;
        instr = 8'h00;
        exp_pc = exp_pc + 8'd1;
        chk("pc_inc", 32'(pc), 32'(exp_pc));
        zero_flag = zf;
        @(negedge clk);
        chk("dec_req", 32'({mem_req, acc_load}), 32'd0);
        @(posedge clk); #1;
        zero_flag = 1'b0;
        if (op == 4'h7 || (op == 4'h8 && zf)) exp_pc = {exp_pc[7:4], i[3:0]};
        if (is_exec(op)) begin
            @(negedge clk);
            chk("exe_load", 32'({acc_load, mem_req}), 32'b10);
            @(posedge clk); #1;
        end
        if (op == 4'hF) chk("halted", 32'(halted), 32'd1);
    endtask

    initial begin
        instr = 8'h00;
        do_reset();

        // ADD #3 first: pc 00 -> 01, acc_load two cycles after ir_load
        run_instr(8'h13, 1'b0, 0);
        chk("add_pc", 32'(pc), 32'h01);
        run_instr(8'h27, 1'b0, 2);
        run_instr(8'h3A, 1'b0, 0);
        run_instr(8'h41, 1'b0, 1);
        run_instr(8'h5F, 1'b0, 0);
        run_instr(8'h6C, 1'b0, 3);
        run_instr(8'h9C, 1'b0, 0);
        run_instr(8'hE1, 1'b1, 0);
        // one wait short of the timeout must still complete
        run_instr(8'h00, 1'b0, 14);

        while (exp_pc != 8'h3A) run_instr(8'h00, 1'b0, 0);
        run_instr(8'h75, 1'b0, 0);
        chk("jmp_pc", 32'(pc), 32'h35);
        run_instr(8'h89, 1'b0, 0);
        chk("jz0_pc", 32'(pc), 32'h36);
        run_instr(8'h89, 1'b1, 0);
        chk("jz1_pc", 32'(pc), 32'h39);

        while (exp_pc != 8'hFF) run_instr(8'h00, 1'b0, 0);
        run_instr(8'h00, 1'b0, 0);
        chk("wrap_pc", 32'(pc), 32'h00);

        // ADD aborted by reset in its EXECUTE cycle
        mem_ready = 1'b1;
        instr = 8'h12;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_acc", 32'(acc_load), 32'd0);
        chk("abort_pc", 32'(pc), 32'(RESET_PC));
        @(negedge clk);
        chk("abort_acc_neg", 32'(acc_load), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_pc = RESET_PC;

        // HLT is sticky, pc frozen, memory ignored
        run_instr(8'h01, 1'b0, 0);
        run_instr(8'hF0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b1;
            instr = 8'h13;
            @(negedge clk);
            chk("halt_hold", 32'({halted, mem_req, ir_load, acc_load}), 32'b1000);
            chk("halt_pc", 32'(pc), 32'(exp_pc));
            @(posedge clk); #1;
        end
        do_reset();
        chk("post_halt", 32'({halted, pc}), 32'(RESET_PC));

        // 15 stalled fetch cycles -> FAULT, sticky even once memory responds
        for (int k = 0; k < 15; k++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            chk("to_wait", 32'({fault, mem_req}), 32'b01);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_fault", 32'({fault, mem_req}), 32'b10);
        mem_ready = 1'b1;
        instr = 8'h13;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("fault_hold", 32'({fault, mem_req, ir_load, acc_load}), 32'b1000);
            chk("fault_pc", 32'(pc), 32'(RESET_PC));
        end
        mem_ready = 1'b0;

        chk("acc_q_left", 32'(acc_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
